// File: rtl/clock_divider_bank_pkg.sv
// Shared constants and helpers for the programmable clock divider bank.
package clock_divider_bank_pkg;

  // Smallest divisor that still yields a distinct high and low phase.
  localparam int MIN_DIVISOR = 2;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_bank_channel.sv
// One divider channel: counter, active divisor, staged divisor and pending flag.
// A staged divisor is applied only at a wrap or while the channel is stopped.
module clock_divider_channel
  import clock_divider_bank_pkg::*;
#(
  parameter int COUNT_WIDTH   = 16,
  parameter int RESET_DIVISOR = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_divisor,
  input  logic                   enable,
  output logic                   div_clock,
  output logic                   tick,
  output logic                   pending
);

  localparam logic [COUNT_WIDTH-1:0] MIN_D   = COUNT_WIDTH'(MIN_DIVISOR);
  localparam logic [COUNT_WIDTH-1:0] RESET_D = COUNT_WIDTH'(RESET_DIVISOR);
  localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] counter_reg, counter_next;
  logic [COUNT_WIDTH-1:0] divisor_reg, divisor_next;
  logic [COUNT_WIDTH-1:0] staged_reg, staged_next;
  logic                   pending_reg, pending_next;
  logic                   div_reg, div_next;
  logic                   tick_reg, tick_next;
  logic [COUNT_WIDTH-1:0] clamped_divisor;
  logic [COUNT_WIDTH-1:0] counter_inc;
  logic                   wrap;

  assign clamped_divisor = (load_divisor < MIN_D) ? MIN_D : load_divisor;
  assign counter_inc     = counter_reg + ONE;
  assign wrap            = (counter_reg == divisor_reg - ONE);

  always_comb begin
    counter_next = counter_reg;
    divisor_next = divisor_reg;
    staged_next  = staged_reg;
    pending_next = pending_reg;
    div_next     = div_reg;
    tick_next    = 1'b0;

    if (enable) begin
      if (wrap) begin
        counter_next = '0;
        div_next     = 1'b1;
        tick_next    = 1'b1;
        if (pending_reg) begin
          divisor_next = staged_reg;
          pending_next = 1'b0;
        end
      end else begin
        counter_next = counter_inc;
        div_next     = (counter_inc < (divisor_reg >> 1));
      end
    end else begin
      div_next = 1'b0;
      if (pending_reg) begin
        divisor_next = staged_reg;
        pending_next = 1'b0;
      end
      // Parked one short of the (possibly new) divisor so re-enable wraps on the first edge.
      counter_next = divisor_next - ONE;
    end

    // A load always stages; any wrap above has already consumed the previous staged value.
    if (load) begin
      staged_next  = clamped_divisor;
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter_reg <= RESET_D - ONE;
      divisor_reg <= RESET_D;
      staged_reg  <= RESET_D;
      pending_reg <= 1'b0;
      div_reg     <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      counter_reg <= counter_next;
      divisor_reg <= divisor_next;
      staged_reg  <= staged_next;
      pending_reg <= pending_next;
      div_reg     <= div_next;
      tick_reg    <= tick_next;
    end
  end

  assign div_clock = div_reg;
  assign tick      = tick_reg;
  assign pending   = pending_reg;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent run-time programmable integer clock dividers.
// Decodes the shared load port into per-channel strobes; all timing lives in the channels.
module clock_divider_bank
  import clock_divider_bank_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int COUNT_WIDTH   = 16,
  parameter int RESET_DIVISOR = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             load,
  input  logic [sel_width(CHANNELS)-1:0]   load_channel,
  input  logic [COUNT_WIDTH-1:0]           load_divisor,
  input  logic [CHANNELS-1:0]              channel_enable,
  output logic [CHANNELS-1:0]              div_clock,
  output logic [CHANNELS-1:0]              tick,
  output logic [CHANNELS-1:0]              pending
);

  logic [CHANNELS-1:0] load_strobe;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
      // Selects at or beyond CHANNELS match no channel and are dropped.
      assign load_strobe[gi] = load && (32'(load_channel) == gi);

      clock_divider_channel #(
        .COUNT_WIDTH   (COUNT_WIDTH),
        .RESET_DIVISOR (RESET_DIVISOR)
      ) u_channel (
        .clock        (clock),
        .reset        (reset),
        .load         (load_strobe[gi]),
        .load_divisor (load_divisor),
        .enable       (channel_enable[gi]),
        .div_clock    (div_clock[gi]),
        .tick         (tick[gi]),
        .pending      (pending[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: directed vector table, corner sequences
// and randomized traffic against a period/phase reference model.
module tb_clock_divider_bank;

  // Three channels so that select value 3 is representable yet out of range.
  localparam int CH = 3;
  localparam int W  = 16;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [1:0]    load_channel;
  logic [W-1:0]  load_divisor;
  logic [CH-1:0] channel_enable;
  logic [CH-1:0] div_clock;
  logic [CH-1:0] tick;
  logic [CH-1:0] pending;

  clock_divider_bank #(
    .CHANNELS      (CH),
    .COUNT_WIDTH   (W),
    .RESET_DIVISOR (RD)
  ) dut (
    .clock          (clk),
    .reset          (rst),
    .load           (load),
    .load_channel   (load_channel),
    .load_divisor   (load_divisor),
    .channel_enable (channel_enable),
    .div_clock      (div_clock),
    .tick           (tick),
    .pending        (pending)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: active period length, staged value, and position within the period.
  int m_div[CH];
  int m_stg[CH];
  int m_pend[CH];
  int m_phase[CH];
  logic [CH-1:0] exp_tick, exp_div, exp_pend;

  typedef struct {
    logic [CH-1:0] en;
    logic          ld;
    logic [1:0]    ch;
    logic [W-1:0]  dv;
    logic          t0;
    logic          d0;
    logic          p0;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_div[i]   = RD;
      m_stg[i]   = RD;
      m_pend[i]  = 0;
      m_phase[i] = RD - 1;
    end
    exp_tick = '0;
    exp_div  = '0;
    exp_pend = '0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < CH; i++) begin
      if (channel_enable[i]) begin
        if (m_phase[i] == m_div[i] - 1) begin
          m_phase[i] = 0;
          if (m_pend[i] != 0) begin
            m_div[i]  = m_stg[i];
            m_pend[i] = 0;
          end
        end else begin
          m_phase[i] = m_phase[i] + 1;
        end
        exp_tick[i] = (m_phase[i] == 0);
        exp_div[i]  = (m_phase[i] < m_div[i] / 2);
      end else begin
        if (m_pend[i] != 0) begin
          m_div[i]  = m_stg[i];
          m_pend[i] = 0;
        end
        m_phase[i]  = m_div[i] - 1;
        exp_tick[i] = 1'b0;
        exp_div[i]  = 1'b0;
      end
      if (load && int'(load_channel) == i) begin
        m_stg[i]  = (int'(load_divisor) < 2) ? 2 : int'(load_divisor);
        m_pend[i] = 1;
      end
      exp_pend[i] = (m_pend[i] != 0);
    end
  endtask

  task automatic step(input logic [CH-1:0] en, input logic ld, input logic [1:0] ch,
                      input logic [W-1:0] dv);
    channel_enable = en;
    load           = ld;
    load_channel   = ch;
    load_divisor   = dv;
    @(posedge clk);
    model_edge();
    #1;
    $display("t=%0t en=%b ld=%b ch=%0d dv=%0d tick=%b div=%b pend=%b",
             $time, en, ld, ch, dv, tick, div_clock, pending);
    check("tick", int'(tick), int'(exp_tick));
    check("div_clock", int'(div_clock), int'(exp_div));
    check("pending", int'(pending), int'(exp_pend));
    load = 1'b0;
  endtask

  // Called just after a tick on channel ch; measures the following period and its high time.
  task automatic measure_period(input int ch, input int exp_len);
    int n;
    int high;
    n    = 0;
    high = 0;
    do begin
      high += int'(div_clock[ch]);
      step(channel_enable, 1'b0, 2'd0, '0);
      n++;
    end while (!tick[ch] && n < 200);
    check($sformatf("period_ch%0d", ch), n, exp_len);
    check($sformatf("high_ch%0d", ch), high, exp_len / 2);
  endtask

  initial begin
    // Directed ch0 trace: D=4, load 5 mid-period, load 0 on a wrap, load 1 mid-period.
    tbl[0]  = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{3'b001, 1'b1, 2'd0, 16'd5, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{3'b001, 1'b1, 2'd0, 16'd0, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b0};
    tbl[21] = '{3'b001, 1'b1, 2'd0, 16'd1, 1'b0, 1'b0, 1'b1};
    tbl[22] = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b0};
    tbl[23] = '{3'b001, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};

    rst            = 1'b1;
    load           = 1'b0;
    load_channel   = '0;
    load_divisor   = '0;
    channel_enable = '0;
    model_reset();
    #12;
    check("reset_tick", int'(tick), 0);
    check("reset_div_clock", int'(div_clock), 0);
    check("reset_pending", int'(pending), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].en, tbl[i].ld, tbl[i].ch, tbl[i].dv);
      check($sformatf("vec%0d_tick0", i), int'(tick[0]), int'(tbl[i].t0));
      check($sformatf("vec%0d_div0", i), int'(div_clock[0]), int'(tbl[i].d0));
      check($sformatf("vec%0d_pend0", i), int'(pending[0]), int'(tbl[i].p0));
    end

    // Stage 6, then load 7 exactly on the wrap edge: 6 applies now, 7 at the next wrap.
    step(3'b001, 1'b1, 2'd0, 16'd6);
    for (int n = 0; n < 50 && m_phase[0] != m_div[0] - 1; n++)
      step(3'b001, 1'b0, 2'd0, '0);
    step(3'b001, 1'b1, 2'd0, 16'd7);
    check("wrap_load_pending", int'(pending[0]), 1);
    measure_period(0, 6);
    check("after_wrap_pending", int'(pending[0]), 0);
    measure_period(0, 7);

    // Disable ch1 with 8 staged, then re-enable.
    step(3'b011, 1'b0, 2'd0, '0);
    step(3'b011, 1'b0, 2'd0, '0);
    step(3'b011, 1'b1, 2'd1, 16'd8);
    step(3'b001, 1'b0, 2'd0, '0);
    check("disable_div1", int'(div_clock[1]), 0);
    check("disable_pend1", int'(pending[1]), 0);
    step(3'b001, 1'b0, 2'd0, '0);
    step(3'b011, 1'b0, 2'd0, '0);
    check("reenable_tick1", int'(tick[1]), 1);
    measure_period(1, 8);

    // Asynchronous reset mid-period with a staged load, plus an out-of-range load.
    step(3'b011, 1'b1, 2'd1, 16'd5);
    step(3'b011, 1'b0, 2'd0, '0);
    #2;
    rst          = 1'b1;
    load         = 1'b1;
    load_channel = 2'd3;
    load_divisor = 16'd9;
    #1;
    check("async_rst_tick", int'(tick), 0);
    check("async_rst_div", int'(div_clock), 0);
    check("async_rst_pend", int'(pending), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(3'b011, 1'b1, 2'd3, 16'd9);
    check("oor_load_pend", int'(pending), 0);
    measure_period(0, RD);
    measure_period(1, RD);

    // Randomized traffic against the model.
    begin
      logic [CH-1:0] en;
      en = 3'b111;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 9) == 0) en = CH'($urandom);
        step(en, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
             W'($urandom_range(0, 12)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
